// File: rtl/ldpc_mem_pkg.sv
// Shared definitions for the LDPC intrinsic-message memory subsystem.
// Holds the default LLR/address widths and the bank index type used by the ping-pong pair.
package ldpc_mem_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 5;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 8;
  localparam int unsigned NUM_BANKS          = 2;

  typedef logic bank_idx_t;

  // Ping-pong partner of a bank.
  function automatic bank_idx_t other_bank(input bank_idx_t b);
    return bank_idx_t'(~b);
  endfunction

endpackage

// File: rtl/int_ram_loader_if.sv
// Bundle of the LLR stream, decoder read port and the per-bank RAM control/data ports.
// The slave modport is the loader's view; the master modport is the surrounding system's view.
interface int_ram_loader_if
  import ldpc_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  // Channel LLR stream
  logic [DATA_WIDTH-1:0] llr_in;
  logic                  llr_valid;
  logic                  llr_ready;

  // Decoder side
  logic                  frame_avail;
  bank_idx_t             frame_bank;
  logic                  dec_rd_en;
  logic [ADDR_WIDTH-1:0] dec_address;
  logic                  dec_done;
  logic [DATA_WIDTH-1:0] dec_data;

  // Intrinsic RAM pair
  logic [ADDR_WIDTH-1:0] ram_address  [0:NUM_BANKS-1];
  logic [DATA_WIDTH-1:0] ram_data_in  [0:NUM_BANKS-1];
  logic                  ram_we       [0:NUM_BANKS-1];
  logic                  ram_cs       [0:NUM_BANKS-1];
  logic [DATA_WIDTH-1:0] ram_data_out [0:NUM_BANKS-1];

  modport slave (
    input  llr_in, llr_valid, dec_rd_en, dec_address, dec_done, ram_data_out,
    output llr_ready, frame_avail, frame_bank, dec_data,
           ram_address, ram_data_in, ram_we, ram_cs
  );

  modport master (
    output llr_in, llr_valid, dec_rd_en, dec_address, dec_done, ram_data_out,
    input  llr_ready, frame_avail, frame_bank, dec_data,
           ram_address, ram_data_in, ram_we, ram_cs
  );

endinterface

// File: rtl/int_ram_loader.sv
// Write-side controller and ping-pong arbiter for the two intrinsic-message RAM banks.
// Fills the free bank with one frame of LLRs and lends the full bank to the decoder until released.
module int_ram_loader
  import ldpc_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned FRAME_LEN  = 256
) (
  input  logic           clk,
  input  logic           reset,
  int_ram_loader_if.slave bus
);

  localparam int unsigned LAST_IDX = FRAME_LEN - 1;

  // Registered state
  bank_idx_t              r_wr_bank;
  bank_idx_t              r_rd_bank;
  bank_idx_t              r_rd_bank_q;
  logic [NUM_BANKS-1:0]   r_bank_full;
  logic [ADDR_WIDTH-1:0]  r_wr_cnt;

  // Combinational decode and next state
  logic                   w_llr_ready;
  logic                   w_accept;
  logic                   w_last_beat;
  logic                   w_frame_avail;
  logic                   w_rd_access;
  logic                   w_release;
  bank_idx_t              w_wr_bank_nxt;
  bank_idx_t              w_rd_bank_nxt;
  logic [NUM_BANKS-1:0]   w_bank_full_nxt;
  logic [ADDR_WIDTH-1:0]  w_wr_cnt_nxt;

  // Handshake and read-grant decode; ready is forced low while reset is held.
  always_comb begin
    w_llr_ready   = reset & ~r_bank_full[r_wr_bank];
    w_accept      = bus.llr_valid & w_llr_ready;
    w_last_beat   = (r_wr_cnt == ADDR_WIDTH'(LAST_IDX));
    w_frame_avail = r_bank_full[r_rd_bank];
    w_rd_access   = w_frame_avail & bus.dec_rd_en;
    w_release     = w_frame_avail & bus.dec_done;
  end

  // Writer and reader only ever touch different banks, so both updates can land together.
  always_comb begin
    w_wr_cnt_nxt    = r_wr_cnt;
    w_wr_bank_nxt   = r_wr_bank;
    w_rd_bank_nxt   = r_rd_bank;
    w_bank_full_nxt = r_bank_full;
    if (w_accept) begin
      if (w_last_beat) begin
        w_wr_cnt_nxt               = '0;
        w_bank_full_nxt[r_wr_bank] = 1'b1;
        w_wr_bank_nxt              = other_bank(r_wr_bank);
      end else begin
        w_wr_cnt_nxt = r_wr_cnt + ADDR_WIDTH'(1);
      end
    end
    if (w_release) begin
      w_bank_full_nxt[r_rd_bank] = 1'b0;
      w_rd_bank_nxt              = other_bank(r_rd_bank);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_rd_bank_q <= 1'b0;
      r_bank_full <= '0;
      r_wr_cnt    <= '0;
    end else begin
      r_wr_bank   <= w_wr_bank_nxt;
      r_rd_bank   <= w_rd_bank_nxt;
      r_rd_bank_q <= r_rd_bank;
      r_bank_full <= w_bank_full_nxt;
      r_wr_cnt    <= w_wr_cnt_nxt;
    end
  end

  // Per-bank RAM port steering; an idle bank sees all zeros.
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    localparam bank_idx_t BANK = bank_idx_t'(g);

    logic                  w_cs;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_din;

    always_comb begin
      w_cs   = 1'b0;
      w_we   = 1'b0;
      w_addr = '0;
      w_din  = '0;
      if (w_accept && (r_wr_bank == BANK)) begin
        w_cs   = 1'b1;
        w_we   = 1'b1;
        w_addr = r_wr_cnt;
        w_din  = bus.llr_in;
      end else if (w_rd_access && (r_rd_bank == BANK)) begin
        w_cs   = 1'b1;
        w_addr = bus.dec_address;
      end
    end

    assign bus.ram_cs[g]      = w_cs;
    assign bus.ram_we[g]      = w_we;
    assign bus.ram_address[g] = w_addr;
    assign bus.ram_data_in[g] = w_din;
  end

  // Read data follows the bank that was selected on the request cycle.
  assign bus.llr_ready   = w_llr_ready;
  assign bus.frame_avail = w_frame_avail;
  assign bus.frame_bank  = r_rd_bank;
  assign bus.dec_data    = reset ? bus.ram_data_out[r_rd_bank_q] : '0;

endmodule

// File: tb/tb_int_ram_loader.sv
// Bench for int_ram_loader: directed scenarios then random traffic against a frame-queue model.
// A pair of behavioural 1-cycle-latency RAMs sits on the ram_* ports.
module tb_int_ram_loader;
  import ldpc_mem_pkg::*;

  localparam int unsigned DW         = 5;
  localparam int unsigned AW         = 8;
  localparam int unsigned FL         = 4;
  localparam int unsigned RUN_CYCLES = 1500;

  typedef logic [FL-1:0][DW-1:0] frame_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int_ram_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  int_ram_loader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FRAME_LEN (FL)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  // Behavioural RAM pair
  logic [DW-1:0] mem [NUM_BANKS][2**AW];
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_ram
    always @(posedge clk) begin
      if (bus.ram_cs[g]) begin
        if (bus.ram_we[g]) mem[g][bus.ram_address[g]] <= bus.ram_data_in[g];
        else               bus.ram_data_out[g] <= mem[g][bus.ram_address[g]];
      end
    end
  end

  // Reference model: completed frames waiting for/owned by the decoder, plus the frame being filled.
  frame_t        done_q[$];
  frame_t        cur;
  int            cur_len;
  int            n_written;
  int            n_released;
  logic          pend;
  logic [DW-1:0] pend_val;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    done_q.delete();
    cur        = '0;
    cur_len    = 0;
    n_written  = 0;
    n_released = 0;
    pend       = 1'b0;
  endtask

  // Hold reset for n cycles with busy-looking inputs; every output must read zero.
  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n           = 1'b0;
      bus.llr_valid   = 1'b1;
      bus.llr_in      = DW'($urandom);
      bus.dec_rd_en   = 1'b1;
      bus.dec_address = AW'($urandom_range(0, FL - 1));
      bus.dec_done    = 1'(i % 2);
      #1;
      check("rst llr_ready",   32'(bus.llr_ready),   32'(0));
      check("rst frame_avail", 32'(bus.frame_avail), 32'(0));
      check("rst frame_bank",  32'(bus.frame_bank),  32'(0));
      check("rst dec_data",    32'(bus.dec_data),    32'(0));
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
        check($sformatf("rst ram_cs[%0d]", b),      32'(bus.ram_cs[b]),      32'(0));
        check($sformatf("rst ram_we[%0d]", b),      32'(bus.ram_we[b]),      32'(0));
        check($sformatf("rst ram_address[%0d]", b), 32'(bus.ram_address[b]), 32'(0));
        check($sformatf("rst ram_data_in[%0d]", b), 32'(bus.ram_data_in[b]), 32'(0));
      end
    end
    model_reset();
  endtask

  // One clock of traffic: drive at negedge, check combinational outputs, advance the model.
  task automatic drive_cycle(input logic v, input logic [DW-1:0] d, input logic re,
                             input logic [AW-1:0] a, input logic dn);
    logic      exp_ready;
    logic      exp_avail;
    logic      acc;
    bank_idx_t wb;
    bank_idx_t rb;
    @(negedge clk);
    rst_n           = 1'b1;
    bus.llr_valid   = v;
    bus.llr_in      = d;
    bus.dec_rd_en   = re;
    bus.dec_address = a;
    bus.dec_done    = dn;
    #1;
    exp_ready = (done_q.size() < 2);
    exp_avail = (done_q.size() > 0);
    wb        = bank_idx_t'(n_written % 2);
    rb        = bank_idx_t'(n_released % 2);
    acc       = v & exp_ready;
    check("llr_ready",   32'(bus.llr_ready),   32'(exp_ready));
    check("frame_avail", 32'(bus.frame_avail), 32'(exp_avail));
    check("frame_bank",  32'(bus.frame_bank),  32'(rb));
    if (pend) check("dec_data", 32'(bus.dec_data), 32'(pend_val));
    pend = 1'b0;
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      logic          e_cs;
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_din;
      e_cs   = 1'b0;
      e_we   = 1'b0;
      e_addr = '0;
      e_din  = '0;
      if (acc && b == int'(wb)) begin
        e_cs   = 1'b1;
        e_we   = 1'b1;
        e_addr = AW'(cur_len);
        e_din  = d;
      end else if (exp_avail && re && b == int'(rb)) begin
        e_cs   = 1'b1;
        e_addr = a;
      end
      check($sformatf("ram_cs[%0d]", b),      32'(bus.ram_cs[b]),      32'(e_cs));
      check($sformatf("ram_we[%0d]", b),      32'(bus.ram_we[b]),      32'(e_we));
      check($sformatf("ram_address[%0d]", b), 32'(bus.ram_address[b]), 32'(e_addr));
      check($sformatf("ram_data_in[%0d]", b), 32'(bus.ram_data_in[b]), 32'(e_din));
    end
    if (exp_avail && re) begin
      logic [1:0] idx;
      idx      = a[1:0];
      pend     = 1'b1;
      pend_val = done_q[0][idx];
    end
    if (exp_avail && dn) begin
      void'(done_q.pop_front());
      n_released++;
    end
    if (acc) begin
      cur[cur_len] = d;
      cur_len++;
      if (cur_len == int'(FL)) begin
        done_q.push_back(cur);
        cur_len = 0;
        n_written++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    bus.llr_valid   = 1'b0;
    bus.llr_in      = '0;
    bus.dec_rd_en   = 1'b0;
    bus.dec_address = '0;
    bus.dec_done    = 1'b0;
    model_reset();
    hold_reset(2);

    // One frame 1..4 into bank 0, then a second into bank 1 until both are full.
    for (int k = 1; k <= 8; k++) drive_cycle(1'b1, DW'(k), 1'b0, '0, 1'b0);
    drive_cycle(1'b1, DW'(9), 1'b0, '0, 1'b0);
    // Read back bank 0 addresses 3 and 0.
    drive_cycle(1'b0, '0, 1'b1, AW'(3), 1'b0);
    drive_cycle(1'b0, '0, 1'b1, AW'(0), 1'b0);
    drive_cycle(1'b0, '0, 1'b0, '0, 1'b0);
    // Release bank 0; the waiting beat lands in bank 0 address 0 on the next cycle.
    drive_cycle(1'b1, DW'(9), 1'b0, '0, 1'b1);
    drive_cycle(1'b1, DW'(9), 1'b0, '0, 1'b0);

    // Final beat into bank 1 coincides with bank 0 release and its last read.
    hold_reset(1);
    for (int k = 1; k <= 7; k++) drive_cycle(1'b1, DW'(k + 10), 1'b0, '0, 1'b0);
    drive_cycle(1'b1, DW'(18), 1'b1, AW'(2), 1'b1);
    drive_cycle(1'b0, '0, 1'b1, AW'(3), 1'b0);
    drive_cycle(1'b1, DW'(19), 1'b0, '0, 1'b0);

    // Reset mid-frame discards the partial frame.
    drive_cycle(1'b1, DW'(3), 1'b0, '0, 1'b0);
    drive_cycle(1'b1, DW'(4), 1'b0, '0, 1'b0);
    hold_reset(1);
    drive_cycle(1'b1, DW'(7), 1'b0, '0, 1'b0);

    // Random traffic with occasional resets.
    for (int c = 0; c < int'(RUN_CYCLES); c++) begin
      if ($urandom_range(0, 399) == 0) begin
        hold_reset(1);
      end else begin
        drive_cycle(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom),
                    AW'($urandom_range(0, FL - 1)), 1'($urandom_range(0, 5) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
